// File: rtl/spi_flash_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_read_arbiter
// Purpose  : Round-robin sharing of one SPI NOR flash (READ 0x03, mode 0)
//            between an instruction-fetch port and a data-load port.
// Revision : 1.0
// ============================================================================
module spi_flash_read_arbiter #(
    parameter int          CLK_DIV  = 1,
    parameter int          CS_GAP   = 2,
    parameter logic [7:0]  READ_CMD = 8'h03
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [23:0] i_req_addr,
    output logic        i_rsp_valid,
    output logic [31:0] i_rsp_data,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [23:0] d_req_addr,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        spi_csb,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        busy
);

    localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);
    localparam int         GW       = (CS_GAP < 2) ? 1 : $clog2(CS_GAP + 1);
    localparam logic [GW-1:0] GAP_INIT = GW'(CS_GAP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t         state;
    logic [GW-1:0]  gap_cnt;
    logic           last_grant_d;
    logic           port_d;
    logic [31:0]    tx_sr;
    logic [31:0]    rx_sr;
    logic [5:0]     bit_idx;
    logic [2:0]     phase_cnt;
    logic           grant_i;
    logic           grant_d;
    logic           can_accept;

    assign can_accept = rst_n && (state == IDLE) && (gap_cnt == '0);

    // Port I wins a tie unless it was the most recent grantee.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (can_accept) begin
            if (i_req_valid && (!d_req_valid || last_grant_d)) begin
                grant_i = 1'b1;
            end else if (d_req_valid) begin
                grant_d = 1'b1;
            end
        end
    end

    assign i_req_ready = grant_i;
    assign d_req_ready = grant_d;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            spi_csb      <= 1'b1;
            spi_sclk     <= 1'b0;
            spi_mosi     <= 1'b0;
            i_rsp_valid  <= 1'b0;
            d_rsp_valid  <= 1'b0;
            i_rsp_data   <= '0;
            d_rsp_data   <= '0;
            gap_cnt      <= '0;
            last_grant_d <= 1'b1;
            port_d       <= 1'b0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            bit_idx      <= '0;
            phase_cnt    <= '0;
        end else begin
            i_rsp_valid <= 1'b0;
            d_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_i || grant_d) begin
                        port_d       <= grant_d;
                        last_grant_d <= grant_d;
                        tx_sr        <= {READ_CMD[6:0], (grant_d ? d_req_addr : i_req_addr), 1'b0};
                        spi_mosi     <= READ_CMD[7];
                        spi_csb      <= 1'b0;
                        spi_sclk     <= 1'b0;
                        bit_idx      <= '0;
                        phase_cnt    <= '0;
                        state        <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (phase_cnt != DIV_LAST) begin
                        phase_cnt <= phase_cnt + 3'd1;
                    end else begin
                        phase_cnt <= '0;
                        if (!spi_sclk) begin
                            // Rising SCLK: the upper half of the frame carries read data.
                            spi_sclk <= 1'b1;
                            if (bit_idx[5]) begin
                                rx_sr <= {rx_sr[30:0], spi_miso};
                            end
                        end else if (bit_idx == 6'd63) begin
                            spi_sclk <= 1'b0;
                            spi_csb  <= 1'b1;
                            spi_mosi <= 1'b0;
                            gap_cnt  <= GAP_INIT;
                            state    <= GAP;
                            if (port_d) begin
                                d_rsp_valid <= 1'b1;
                                d_rsp_data  <= {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
                            end else begin
                                i_rsp_valid <= 1'b1;
                                i_rsp_data  <= {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
                            end
                        end else begin
                            spi_sclk <= 1'b0;
                            bit_idx  <= bit_idx + 6'd1;
                            spi_mosi <= (bit_idx < 6'd31) ? tx_sr[31] : 1'b0;
                            tx_sr    <= {tx_sr[30:0], 1'b0};
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt <= GW'(1)) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_read_arbiter
// Purpose  : Directed self-checking bench with a behavioural SPI flash model.
// Revision : 1.0
// ============================================================================
module tb_spi_flash_read_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        i_req_valid = 0, i_req_ready, i_rsp_valid;
    logic [23:0] i_req_addr = '0;
    logic [31:0] i_rsp_data;
    logic        d_req_valid = 0, d_req_ready, d_rsp_valid;
    logic [23:0] d_req_addr = '0;
    logic [31:0] d_rsp_data;
    logic        spi_csb, spi_sclk, spi_mosi, busy;
    logic        spi_miso = 1'b0;

    logic        u2_i_valid = 0, u2_i_ready, u2_i_rsp_valid;
    logic [23:0] u2_i_addr = '0;
    logic [31:0] u2_i_rsp_data;
    logic        u2_d_valid = 0, u2_d_ready, u2_d_rsp_valid;
    logic [23:0] u2_d_addr = '0;
    logic [31:0] u2_d_rsp_data;
    logic        u2_csb, u2_sclk, u2_mosi, u2_busy;

    spi_flash_read_arbiter #(.CLK_DIV(1), .CS_GAP(2), .READ_CMD(8'h03)) u1 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .spi_csb(spi_csb), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .busy(busy)
    );

    spi_flash_read_arbiter #(.CLK_DIV(2), .CS_GAP(2), .READ_CMD(8'h03)) u2 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(u2_i_valid), .i_req_ready(u2_i_ready), .i_req_addr(u2_i_addr),
        .i_rsp_valid(u2_i_rsp_valid), .i_rsp_data(u2_i_rsp_data),
        .d_req_valid(u2_d_valid), .d_req_ready(u2_d_ready), .d_req_addr(u2_d_addr),
        .d_rsp_valid(u2_d_rsp_valid), .d_rsp_data(u2_d_rsp_data),
        .spi_csb(u2_csb), .spi_sclk(u2_sclk), .spi_mosi(u2_mosi), .spi_miso(spi_miso),
        .busy(u2_busy)
    );

    // One flash model, switched between the two controllers.
    logic sel = 1'b0;
    wire f_csb  = sel ? u2_csb  : spi_csb;
    wire f_sclk = sel ? u2_sclk : spi_sclk;
    wire f_mosi = sel ? u2_mosi : spi_mosi;

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        if (a == 24'h000100) return 8'h13;
        if (a >= 24'h000101 && a <= 24'h000103) return 8'h00;
        return (a[7:0] ^ a[15:8] ^ a[23:16]) + 8'h3C;
    endfunction

    int          fcnt = 0;
    int          fones = 0;
    logic [31:0] fframe = '0;

    always @(negedge f_csb) begin
        fcnt   = 0;
        fframe = '0;
    end

    always @(posedge f_sclk) begin
        if (!f_csb) begin
            if (fcnt < 32) fframe = {fframe[30:0], f_mosi};
            else if (f_mosi) fones++;
            fcnt++;
        end
    end

    always @(negedge f_sclk) begin
        logic [7:0] b;
        int j;
        if (!f_csb && fcnt >= 32 && fcnt < 64) begin
            j = fcnt - 32;
            b = mem_byte(fframe[23:0] + 24'(j / 8));
            spi_miso = b[7 - (j % 8)];
        end
    end

    int i_pulses = 0, d_pulses = 0, low_run = 0, low_ok = 0, low_bad = 0;
    always @(negedge clk) begin
        if (i_rsp_valid) i_pulses++;
        if (d_rsp_valid) d_pulses++;
        if (!rst_n) begin
            low_run = 0;
        end else if (!spi_csb) begin
            low_run++;
        end else begin
            if (low_run == 128) low_ok++;
            else if (low_run != 0) low_bad++;
            low_run = 0;
        end
    end

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic u1_read(input bit pd, input logic [23:0] a,
                           output int hs, output int rc, output logic [31:0] data);
        hs = -1; rc = -1; data = '0;
        if (pd) begin d_req_valid = 1; d_req_addr = a; end
        else    begin i_req_valid = 1; i_req_addr = a; end
        for (int c = 0; c < 400 && hs < 0; c++) begin
            @(negedge clk);
            if (pd ? d_req_ready : i_req_ready) hs = cyc;
            @(posedge clk);
            #1;
        end
        i_req_valid = 0;
        d_req_valid = 0;
        if (hs >= 0) begin
            for (int c = 0; c < 600 && rc < 0; c++) begin
                @(negedge clk);
                if (pd ? d_rsp_valid : i_rsp_valid) begin
                    rc = cyc;
                    data = pd ? d_rsp_data : i_rsp_data;
                end
            end
        end
        check("read_completed", 64'(hs >= 0 && rc >= 0), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs, rc, pulses_snap, low_snap, nh, nr, ii, di, both_rdy;
        logic [31:0] data;
        logic [23:0] ia[2], da[2];
        int hs_c[4], rs_c[4];
        bit hs_p[4], rs_p[4];
        logic [31:0] rs_d[4], exp_d[4];
        bit hi, hd;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_csb", spi_csb, 1);
        check("rst_sclk", spi_sclk, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_i_ready", i_req_ready, 0);
        check("rst_rsp_valid", {i_rsp_valid, d_rsp_valid}, 0);
        check("rst_rsp_data", {i_rsp_data, d_rsp_data}, 0);
        i_req_valid = 1;
        #1 check("rst_ready_held_low", i_req_ready, 0);
        i_req_valid = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single I read at 0x000100
        u1_read(1'b0, 24'h000100, hs, rc, data);
        check("t1_frame", fframe, 32'h03000100);
        check("t1_latency", rc - hs, 129);
        check("t1_data", data, 32'h00000013);
        check("t1_mosi_zero_in_data", fones, 0);
        check("t1_i_pulses", i_pulses, 1);
        check("t1_d_pulses", d_pulses, 0);
        check("t1_csb_low_128", {low_ok, low_bad}, {32'd1, 32'd0});

        // Both ports held valid for four transactions
        do_reset();
        ia[0] = 24'h000010; ia[1] = 24'h000100;
        da[0] = 24'h000020; da[1] = 24'h0A0B0C;
        exp_d[0] = 32'h4F4E4D4C; exp_d[1] = 32'h5F5E5D5C;
        exp_d[2] = 32'h00000013; exp_d[3] = 32'h4A4B4849;
        for (int k = 0; k < 4; k++) begin
            hs_c[k] = 0; rs_c[k] = 0; hs_p[k] = 0; rs_p[k] = 0; rs_d[k] = '0;
        end
        nh = 0; nr = 0; ii = 0; di = 0; both_rdy = 0;
        low_snap = low_ok;
        i_req_valid = 1; i_req_addr = ia[0];
        d_req_valid = 1; d_req_addr = da[0];
        for (int c = 0; c < 1200 && nr < 4; c++) begin
            @(negedge clk);
            hi = i_req_valid && i_req_ready;
            hd = d_req_valid && d_req_ready;
            if (hi && hd) both_rdy++;
            if ((hi || hd) && nh < 4) begin hs_c[nh] = cyc; hs_p[nh] = hd; nh++; end
            if (i_rsp_valid && nr < 4) begin rs_c[nr] = cyc; rs_d[nr] = i_rsp_data; rs_p[nr] = 0; nr++; end
            if (d_rsp_valid && nr < 4) begin rs_c[nr] = cyc; rs_d[nr] = d_rsp_data; rs_p[nr] = 1; nr++; end
            @(posedge clk);
            #1;
            if (hi) begin ii++; if (ii >= 2) i_req_valid = 0; else i_req_addr = ia[ii]; end
            if (hd) begin di++; if (di >= 2) d_req_valid = 0; else d_req_addr = da[di]; end
        end
        i_req_valid = 0;
        d_req_valid = 0;
        check("rr_count", {nh, nr}, {32'd4, 32'd4});
        check("rr_never_both_ready", both_rdy, 0);
        check("rr_grant_order", {hs_p[0], hs_p[1], hs_p[2], hs_p[3]}, 4'b0101);
        check("rr_rsp_port_order", {rs_p[0], rs_p[1], rs_p[2], rs_p[3]}, 4'b0101);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr_data_%0d", k), rs_d[k], exp_d[k]);
            check($sformatf("rr_latency_%0d", k), rs_c[k] - hs_c[k], 129);
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rr_gap_%0d", k), hs_c[k+1] - rs_c[k], 2);
        end
        @(posedge clk);
        #1;
        check("rr_csb_low_128", {low_ok - low_snap, low_bad}, {32'd4, 32'd0});

        // CLK_DIV=2 D read at 0x000004 on the second controller
        sel = 1'b1;
        hs = -1; rc = -1; data = '0;
        u2_d_valid = 1; u2_d_addr = 24'h000004;
        for (int c = 0; c < 400 && hs < 0; c++) begin
            @(negedge clk);
            if (u2_d_ready) hs = cyc;
            @(posedge clk);
            #1;
        end
        u2_d_valid = 0;
        for (int c = 0; c < 800 && rc < 0 && hs >= 0; c++) begin
            @(negedge clk);
            if (u2_d_rsp_valid) begin rc = cyc; data = u2_d_rsp_data; end
        end
        check("div2_latency", rc - hs, 257);
        check("div2_data", data, 32'h43424140);
        check("div2_rising_edges", fcnt, 64);
        check("div2_frame", fframe, 32'h03000004);
        @(posedge clk);
        #1 sel = 1'b0;

        // Reset asserted at bit 40
        hs = -1;
        i_req_valid = 1; i_req_addr = 24'h000040;
        for (int c = 0; c < 400 && hs < 0; c++) begin
            @(negedge clk);
            if (i_req_ready) hs = cyc;
            @(posedge clk);
            #1;
        end
        i_req_valid = 0;
        for (int c = 0; c < 200 && cyc < hs + 81; c++) @(negedge clk);
        check("mid_csb_active", {spi_csb, busy}, 2'b01);
        pulses_snap = i_pulses;
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", {spi_csb, spi_sclk, busy}, 3'b100);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check("mid_no_rsp", i_pulses - pulses_snap, 0);
        check("mid_idle_after", {spi_csb, busy}, 2'b10);
        u1_read(1'b0, 24'h000030, hs, rc, data);
        check("post_rst_data", data, 32'h6F6E6D6C);

        // Top-of-flash address
        u1_read(1'b1, 24'hFFFFFC, hs, rc, data);
        check("top_frame", fframe, 32'h03FFFFFC);
        check("top_data", data, 32'h3B3A3938);
        check("top_latency", rc - hs, 129);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_flash_read_arbiter.md
Name: spi_flash_read_arbiter

Overview:
Shares the single SPI NOR flash (CSB/SCLK/MOSI/MISO on the dedicated output/input pins) between two requesters: instruction fetch (port I) and data load (port D). Each granted request runs one standard READ (0x03) transaction: 8-bit command, 24-bit address, then 32 data bits, returned as a little-endian word. Round-robin arbitration prevents starvation. SPI mode 0, single-bit IO only.

Parameters:
CLK_DIV, 1, system clocks per SCLK half-period (legal 1..8)
CS_GAP, 2, minimum system clocks CSB stays high between transactions (legal >=1)
READ_CMD, 8'h03, command byte shifted out first

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  port I read request
i_req_ready  out  1  port I request accepted (handshake = valid & ready)
i_req_addr  in  24  port I byte address
i_rsp_valid  out  1  one-cycle pulse, i_rsp_data valid
i_rsp_data  out  32  port I read word
d_req_valid  in  1  port D read request
d_req_ready  out  1  port D request accepted
d_req_addr  in  24  port D byte address
d_rsp_valid  out  1  one-cycle pulse, d_rsp_data valid
d_rsp_data  out  32  port D read word
spi_csb  out  1  flash chip select, active low
spi_sclk  out  1  flash clock
spi_mosi  out  1  flash data in (io0)
spi_miso  in  1  flash data out (io1)
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE, spi_csb=1, spi_sclk=0, spi_mosi=0, both ready=0, both rsp_valid=0, rsp_data=0, busy=0, gap counter=0, last_grant=D (port I wins first tie).
- States: IDLE -> SHIFT -> GAP -> IDLE.
- IDLE: ready combinational; at most one asserted. Only one valid -> that port. Both valid -> port other than last_grant. Ready=0 while gap counter nonzero. Handshake in cycle T: latch addr and port, update last_grant, go SHIFT.
- SHIFT: spi_csb=0 from T+1. 64-bit frame {READ_CMD, addr[23:0], 32 don't-care}, MSB first. Bit k (0..63): low phase cycles T+1+2*CLK_DIV*k .. +CLK_DIV-1 (sclk=0, mosi=bit k, set at phase start); high phase the next CLK_DIV cycles (sclk=1). spi_miso sampled on clk edge where sclk rises (first cycle of high phase), bits 32..63 only. mosi=0 during data bits.
- Data assembly: received byte n (n=0..3, arrival order) -> rsp_data[8n+7:8n]; MSB of each byte first.
- Completion at cycle T+1+128*CLK_DIV: spi_csb=1, spi_sclk=0, granted rsp_valid=1 for exactly that cycle with rsp_data stable; other port rsp_valid=0. rsp_data holds until next completion on that port. No response backpressure. Go GAP.
- Latency accept->rsp_valid = 1+128*CLK_DIV cycles (129 at CLK_DIV=1).
- GAP: CS_GAP cycles with csb high, then IDLE; earliest next handshake at completion+CS_GAP.
- valid must stay asserted with stable addr until handshake; dropping it earlier is undefined.
- A port may request again during its own GAP; served per round-robin at IDLE.
- Reset mid-transaction: outputs go to reset values immediately, no rsp_valid, the transaction is discarded; after release ready only in IDLE.
- Address 24'hFFFFFF legal; wrap across top of flash is the flash's behaviour, no controller check.

Test Plan:
- Single I read, CLK_DIV=1, flash word at 0x000100 = bytes 13 00 00 00 -> MOSI frame 03 00 01 00; i_rsp_valid 129 cycles after handshake; i_rsp_data=32'h00000013; d_rsp_valid stays 0.
- I and D valid in same cycle after reset -> I granted first, D handshake exactly CS_GAP cycles after I's rsp_valid; two transactions, each csb low 128 cycles, csb high >=2 cycles between.
- Both held valid continuously for 4 transactions -> grant order I,D,I,D; each rsp_data matches flash model at its address.
- CLK_DIV=2, D read at 0x000004 -> sclk period 4 clks, 64 rising edges, rsp_valid 257 cycles after handshake, MISO sampled only on rising edges.
- rst_n low at bit 40 of a transaction -> spi_csb=1, spi_sclk=0, busy=0 same cycle, no rsp_valid; fresh read after release returns correct data.
- Address 24'hFFFFFC read -> MOSI address bits FF FF FC, data from flash model top word, no controller error.
